rc5_engine: RTL
===============

# rc5_engine

Parametrised RC5-w/r/b block cipher engine with on-chip key expansion, supporting both encryption and decryption. A key is loaded once: the engine expands it into the S table and holds it. The engine then processes any number of 2W-bit blocks, one round per cycle, until the next key load. It sits between the host-side data interface and the rest of the accelerator, and generalises the fixed 32-bit encrypt-only datapath.

## Interface
- W, 32: word width in bits; legal values 16, 32, 64. Block width is 2W.
- KEY_BYTES, 16: key length b in bytes, 1..32.
- MAX_ROUNDS, 20: maximum supported r; sets the S-table depth to 2·MAX_ROUNDS+2 words.
- clk  in  1  clock; the block uses this single clock only.
- rst  in  1  synchronous, active-high reset.
- key_load  in  1  starts key expansion; honoured only in IDLE.
- key  in  8·KEY_BYTES  secret key; byte i = key[8i+7:8i].
- num_rounds  in  5  r, sampled with key_load; values above MAX_ROUNDS saturate to MAX_ROUNDS.
- key_ready  out  1  the S table is valid for the current key.
- start  in  1  begins a block operation; honoured only in IDLE with key_ready=1.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled with start.
- d_in  in  2W  input block; A = d_in[W-1:0], B = d_in[2W-1:W].
- busy  out  1  high in every state except IDLE.
- d_out  out  2W  result block, using the same packing as d_in; held until the next accepted start.
- done  out  1  one-cycle pulse; d_out is valid in the same cycle.

## Operation
- States: IDLE, KINIT, KMIX, WHITEN, ROUND, DONE.
- Derived constants:
  - c = max(1, ceil(8·KEY_BYTES/W)).
  - t = 2(r+1).
  - Magic constants P/Q per W:
    - W=16: B7E1 / 9E37.
    - W=32: B7E15163 / 9E3779B9.
    - W=64: B7E151628AED2A6B / 9E3779B97F4A7C15.
- IDLE + key_load:
  - Latch r and load L[0..c-1] little-endian from key (byte i goes to L[i/(W/8)], bits 8·(i mod W/8)); unused high bytes are zero.
  - Clear key_ready, then go to KINIT.
  - key_load has priority over start in the same cycle.
- KINIT: S[0]=P, then S[k]=S[k-1]+Q mod 2^W; one word per cycle, t cycles.
- KMIX: runs 3·max(t,c) iterations at one per cycle, with A=B=i=j=0 on entry. Each iteration:
  - A = S[i] = (S[i]+A+B) <<< 3.
  - B = L[j] = (L[j]+A+B) <<< (A+B).
  - i = (i+1) mod t; j = (j+1) mod c.
  - On completion: set key_ready=1 and go to IDLE.
- IDLE + start + key_ready: latch A, B, mode and set round index k. Encrypt starts at k=1; decrypt starts at k=r.
- Encrypt path: WHITEN, then r ROUND cycles, then DONE.
  - WHITEN: A += S[0]; B += S[1].
  - ROUND k:
    - A' = ((A^B) <<< B) + S[2k].
    - B' = ((B^A') <<< A') + S[2k+1].
    - Both are computed in one cycle; k increments.
- Decrypt path: r ROUND cycles, then WHITEN, then DONE.
  - ROUND k:
    - B' = ((B-S[2k+1]) >>> A) ^ A.
    - A' = ((A-S[2k]) >>> B') ^ B'.
    - k decrements.
  - WHITEN: B -= S[1]; A -= S[0].
- Arithmetic and rotation rules:
  - All arithmetic is mod 2^W.
  - Rotate amounts use only the low log2(W) bits.
- r = 0: ROUND is skipped entirely, so only WHITEN runs.
- DONE: d_out = {B,A}; done=1 for one cycle; return to IDLE.
- start when key_ready=0 or busy=1: ignored, with no state change.
- key_load while busy: ignored.

## Timing
- Reset values: key_ready=0, busy=0, done=0, d_out=0, state IDLE. The S and L contents are don't-care.
- rst asserted in any state, including mid key-expansion or mid-block, aborts on the next edge and restores the reset values. A host must reload the key afterwards.
- Key expansion: key_load is sampled at edge 0. key_ready rises t + 3·max(t,c) + 1 cycles later. For W=32, r=12, b=16 this is 26+78+1 = 105 cycles.
- Block latency: start is sampled at edge 0. done and the valid d_out appear r+2 cycles later (14 cycles for r=12). busy is high from cycle 1 through the done cycle.
- Back-to-back throughput: a start asserted in the cycle after done is accepted, giving r+3 cycles per block.
- Inputs d_in, mode and key are only sampled at their accept edges and may change freely otherwise.

## Test plan
- Zero-key vector: W=32, r=12, key=0, d_in=0, encrypt → done after 14 cycles with d_out=64'h6D8F4B15_EEDBA521 (A=EEDBA521, B=6D8F4B15).
- Second vector: key=128'h91CEA91001A5556351B241BE19465F91, d_in=64'h6D8F4B15_EEDBA521, encrypt → d_out=64'h52892B5B_AC13C0F7.
- Round trip: decrypt 64'h52892B5B_AC13C0F7 under the second key → 64'h6D8F4B15_EEDBA521. Also round-trip 1000 random blocks at W=16, 32 and 64, and at r=0 and r=MAX_ROUNDS.
- Key-schedule timing: key_load at cycle 0 with r=12 → key_ready=0 through cycle 104 and 1 at cycle 105. A start during expansion is ignored, with busy unaffected.
- Collision rules:
  - key_load and start in the same IDLE cycle → expansion runs and no done pulse follows.
  - start while busy → ignored, and the block in flight finishes with the correct result.
- Reset mid-block: assert rst at cycle 5 of an encrypt → the next cycle shows busy=0, done=0, key_ready=0, d_out=0, and no done pulse occurs afterwards.

Source files
------------

// File: rtl/rc5_engine.sv
`default_nettype none
// ============================================================================
// Module   : rc5_engine
// Purpose  : Parametrised RC5-W/r/b block cipher with on-chip key expansion.
//            A key load expands the secret key into the S table, which is then
//            held and used for any number of encrypt/decrypt block operations.
//            Blocks take one round per cycle.
// Ports    : clk, rst        - single clock, synchronous active-high reset
//            i_key_load      - start key expansion (IDLE only, wins over start)
//            i_key           - secret key, byte i = i_key[8i+7:8i]
//            i_num_rounds    - r, sampled with key load, saturates at MAX_ROUNDS
//            o_key_ready     - S table valid for the current key
//            i_start, i_mode - begin block op (0 = encrypt, 1 = decrypt)
//            i_d_in          - input block {B, A}
//            o_busy          - high in every state except IDLE
//            o_d_out         - result block {B, A}, held until next result
//            o_done          - one-cycle pulse, o_d_out valid in that cycle
// Revision : 1.0 - initial release
// ============================================================================
module rc5_engine #(
  parameter int W          = 32,
  parameter int KEY_BYTES  = 16,
  parameter int MAX_ROUNDS = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_key_load,
  input  logic [8*KEY_BYTES-1:0] i_key,
  input  logic [4:0]             i_num_rounds,
  output logic                   o_key_ready,
  input  logic                   i_start,
  input  logic                   i_mode,
  input  logic [2*W-1:0]         i_d_in,
  output logic                   o_busy,
  output logic [2*W-1:0]         o_d_out,
  output logic                   o_done
);

  localparam int LGW     = $clog2(W);
  localparam int C_WORDS = (8*KEY_BYTES + W - 1) / W;
  localparam int T_MAX   = 2*MAX_ROUNDS + 2;
  localparam int IW      = $clog2(T_MAX + 1);
  localparam int JW      = (C_WORDS > 1) ? $clog2(C_WORDS) : 1;
  localparam int CNTW    = 10;

  localparam logic [63:0] C_P_ALL = (W == 16) ? 64'h0000_0000_0000_B7E1 :
                                    (W == 32) ? 64'h0000_0000_B7E1_5163 :
                                                64'hB7E1_5162_8AED_2A6B;
  localparam logic [63:0] C_Q_ALL = (W == 16) ? 64'h0000_0000_0000_9E37 :
                                    (W == 32) ? 64'h0000_0000_9E37_79B9 :
                                                64'h9E37_79B9_7F4A_7C15;
  localparam logic [W-1:0]    C_P     = C_P_ALL[W-1:0];
  localparam logic [W-1:0]    C_Q     = C_Q_ALL[W-1:0];
  localparam logic [4:0]      C_MAXR  = 5'(MAX_ROUNDS);
  localparam logic [JW-1:0]   C_JLAST = JW'(C_WORDS - 1);
  localparam logic [CNTW-1:0] C_C     = CNTW'(C_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KINIT  = 3'd1,
    ST_KMIX   = 3'd2,
    ST_WHITEN = 3'd3,
    ST_ROUND  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]    r_s [0:T_MAX-1];
  logic [W-1:0]    r_l [0:C_WORDS-1];
  logic [W-1:0]    w_lkey [0:C_WORDS-1];
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [4:0]      r_rounds;
  logic [4:0]      r_k;
  logic            r_mode;
  logic            r_key_ready;
  logic [IW-1:0]   r_i;
  logic [JW-1:0]   r_j;
  logic [CNTW-1:0] r_cnt;
  logic [2*W-1:0]  r_dout;

  logic            w_key_acc;
  logic            w_blk_acc;
  logic [4:0]      w_rounds_sat;
  logic [IW-1:0]   w_t;
  logic [CNTW-1:0] w_tc;
  logic [CNTW-1:0] w_mix_last;
  logic            w_kinit_last;
  logic            w_kmix_last;
  logic            w_round_last;
  logic [IW-1:0]   w_se_idx;
  logic [IW-1:0]   w_so_idx;
  logic [W-1:0]    w_s_even;
  logic [W-1:0]    w_s_odd;
  logic [W-1:0]    w_init;
  logic [W-1:0]    w_ka;
  logic [W-1:0]    w_ksum;
  logic [W-1:0]    w_kb;
  logic [W-1:0]    w_ea;
  logic [W-1:0]    w_eb;
  logic [W-1:0]    w_da;
  logic [W-1:0]    w_db;
  logic [W-1:0]    w_wa;
  logic [W-1:0]    w_wb;

  // Rotations via a doubled word so the amount may be zero without a
  // shift-by-W corner case; only the low log2(W) bits reach here.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LGW-1:0] amt);
    logic [2*W-1:0] dbl;
    dbl = {x, x} << amt;
    return dbl[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LGW-1:0] amt);
    logic [2*W-1:0] dbl;
    dbl = {x, x} >> amt;
    return dbl[W-1:0];
  endfunction

  // Little-endian key bytes into L words; bytes past the key length are zero.
  for (genvar gw = 0; gw < C_WORDS; gw++) begin : g_lword
    for (genvar gb = 0; gb < W/8; gb++) begin : g_lbyte
      if (gw*(W/8) + gb < KEY_BYTES) begin : g_key
        assign w_lkey[gw][8*gb +: 8] = i_key[8*(gw*(W/8) + gb) +: 8];
      end else begin : g_pad
        assign w_lkey[gw][8*gb +: 8] = 8'h00;
      end
    end
  end

  assign w_rounds_sat = (i_num_rounds > C_MAXR) ? C_MAXR : i_num_rounds;
  assign w_t          = IW'({1'b0, r_rounds, 1'b0} + 7'd2);
  assign w_tc         = (CNTW'(w_t) > C_C) ? CNTW'(w_t) : C_C;
  assign w_mix_last   = w_tc + w_tc + w_tc - CNTW'(1);
  assign w_kinit_last = (r_i == w_t - IW'(1));
  assign w_kmix_last  = (r_cnt == w_mix_last);
  assign w_round_last = r_mode ? (r_k == 5'd1) : (r_k == r_rounds);

  assign w_se_idx = IW'({r_k, 1'b0});
  assign w_so_idx = IW'({r_k, 1'b1});
  assign w_s_even = r_s[w_se_idx];
  assign w_s_odd  = r_s[w_so_idx];

  // KINIT keeps the previous table word in r_a to form the next one.
  assign w_init = (r_i == '0) ? C_P : r_a + C_Q;

  // Key mixing: the new A feeds the B update in the same cycle.
  assign w_ka   = rotl(r_s[r_i] + r_a + r_b, LGW'(3));
  assign w_ksum = w_ka + r_b;
  assign w_kb   = rotl(r_l[r_j] + w_ksum, w_ksum[LGW-1:0]);

  assign w_ea = rotl(r_a ^ r_b, r_b[LGW-1:0]) + w_s_even;
  assign w_eb = rotl(r_b ^ w_ea, w_ea[LGW-1:0]) + w_s_odd;
  assign w_db = rotr(r_b - w_s_odd, r_a[LGW-1:0]) ^ r_a;
  assign w_da = rotr(r_a - w_s_even, w_db[LGW-1:0]) ^ w_db;

  assign w_wa = r_mode ? (r_a - r_s[0]) : (r_a + r_s[0]);
  assign w_wb = r_mode ? (r_b - r_s[1]) : (r_b + r_s[1]);

  assign o_key_ready = r_key_ready;
  assign o_d_out     = r_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_key_acc   = 1'b0;
    w_blk_acc   = 1'b0;
    o_busy      = (r_state != ST_IDLE);
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_key_load) begin
          w_key_acc   = 1'b1;
          w_state_nxt = ST_KINIT;
        end else if (i_start && r_key_ready) begin
          w_blk_acc   = 1'b1;
          // Decrypt runs rounds first; with r=0 both paths are whitening only.
          w_state_nxt = (i_mode && (r_rounds != 5'd0)) ? ST_ROUND : ST_WHITEN;
        end
      end
      ST_KINIT: begin
        if (w_kinit_last) begin
          w_state_nxt = ST_KMIX;
        end
      end
      ST_KMIX: begin
        if (w_kmix_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WHITEN: begin
        w_state_nxt = (!r_mode && (r_rounds != 5'd0)) ? ST_ROUND : ST_DONE;
      end
      ST_ROUND: begin
        if (w_round_last) begin
          w_state_nxt = r_mode ? ST_WHITEN : ST_DONE;
        end
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_ready <= 1'b0;
      r_dout      <= '0;
      r_rounds    <= '0;
      r_k         <= '0;
      r_mode      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_key_acc) begin
            r_key_ready <= 1'b0;
            r_rounds    <= w_rounds_sat;
            r_i         <= '0;
          end else if (w_blk_acc) begin
            r_a    <= i_d_in[W-1:0];
            r_b    <= i_d_in[2*W-1:W];
            r_mode <= i_mode;
            r_k    <= i_mode ? r_rounds : 5'd1;
          end
        end
        ST_KINIT: begin
          if (w_kinit_last) begin
            r_i   <= '0;
            r_j   <= '0;
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
          end else begin
            r_i <= r_i + IW'(1);
            r_a <= w_init;
          end
        end
        ST_KMIX: begin
          r_a   <= w_ka;
          r_b   <= w_kb;
          r_i   <= w_kinit_last ? '0 : r_i + IW'(1);
          r_j   <= (r_j == C_JLAST) ? '0 : r_j + JW'(1);
          r_cnt <= r_cnt + CNTW'(1);
          if (w_kmix_last) begin
            r_key_ready <= 1'b1;
          end
        end
        ST_WHITEN: begin
          r_a <= w_wa;
          r_b <= w_wb;
          if (w_state_nxt == ST_DONE) begin
            r_dout <= {w_wb, w_wa};
          end
        end
        ST_ROUND: begin
          if (r_mode) begin
            r_a <= w_da;
            r_b <= w_db;
            r_k <= r_k - 5'd1;
          end else begin
            r_a <= w_ea;
            r_b <= w_eb;
            r_k <= r_k + 5'd1;
            if (w_round_last) begin
              r_dout <= {w_eb, w_ea};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Key storage carries no reset: its contents are meaningless until the
  // next key load completes and key_ready gates every use.
  always_ff @(posedge clk) begin
    if (w_key_acc) begin
      for (int n = 0; n < C_WORDS; n++) begin
        r_l[n] <= w_lkey[n];
      end
    end else if (r_state == ST_KMIX) begin
      r_l[r_j] <= w_kb;
    end
    if (r_state == ST_KINIT) begin
      r_s[r_i] <= w_init;
    end else if (r_state == ST_KMIX) begin
      r_s[r_i] <= w_ka;
    end
  end

endmodule
`default_nettype wire
